// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one fulladder time-shared across WIDTH bits, LSB first.
// Optional subtract mode is enabled with `define SERIAL_ADD_SUB_EN (adds the `sub` port).

module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sha_q, shb_q, res_q;
  logic [WIDTH-1:0]  sum_q;
  logic              carry_q, cout_q;
  logic [CntW-1:0]   cnt_q;
  logic              fa_sum, fa_cout;
  logic [WIDTH-1:0]  res_shift;
  logic              last_bit;
  logic [WIDTH-1:0]  b_load;
  logic              carry_load;

  fulladder u_fa (
    .a    (sha_q[0]),
    .b    (shb_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Result register fills from the MSB so the LSB lands in bit 0 after WIDTH shifts.
  if (WIDTH == 1) begin : g_res_w1
    assign res_shift = fa_sum;
  end else begin : g_res_wn
    assign res_shift = {fa_sum, res_q[WIDTH-1:1]};
  end

  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
  // Subtract as A + ~B + 1; final carry of 1 means no borrow.
  assign b_load     = sub ? ~B : B;
  assign carry_load = sub ? 1'b1 : Cin;
`else
  assign b_load     = B;
  assign carry_load = Cin;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StIdle:  busy = 1'b0;
      StRun:   busy = 1'b1;
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sha_q   <= '0;
      shb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sha_q   <= A;
            shb_q   <= b_load;
            res_q   <= '0;
            carry_q <= carry_load;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          sha_q   <= sha_q >> 1;
          shb_q   <= shb_q >> 1;
          res_q   <= res_shift;
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + 1'b1;
          // Visible result only updates on completion; it holds across the next operation.
          if (last_bit) begin
            sum_q  <= res_shift;
            cout_q <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=4 and WIDTH=1.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] A = '0, B = '0;
  logic       Cin = 1'b0;
  logic       busy, done, Cout;
  logic [3:0] Sum;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

`ifdef SERIAL_ADD_SUB_EN
  logic       sub = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [4:0] last_res;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .A     (a1),
    .B     (b1),
    .Cin   (cin1),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (1'b0),
`endif
    .busy  (busy1),
    .done  (done1),
    .Sum   (sum1),
    .Cout  (cout1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=4 operation; returns in the done cycle so the next call starts at minimum spacing.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic cin,
                       input logic [4:0] exp, input bit chk_hold, input string tag);
    int k;
    int busy_n;
    bit seen;
    @(negedge clk);
    check({tag, " idle busy"}, 64'(busy), 64'd0);
    check({tag, " idle done"}, 64'(done), 64'd0);
    A = a; B = b; Cin = cin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = ~a; B = ~b; Cin = ~cin;
    k = 0; busy_n = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      if (busy) busy_n++;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (chk_hold) check({tag, " hold"}, 64'({Cout, Sum}), 64'(last_res));
        @(negedge clk);
        k++;
      end
    end
    check({tag, " latency"}, 64'(k), 64'd4);
    check({tag, " busy cycles"}, 64'(busy_n), 64'd5);
    check({tag, " result"}, 64'({Cout, Sum}), 64'(exp));
    last_res = exp;
  endtask

  task automatic do_op1(input logic a, input logic b, input logic cin, input logic [1:0] exp);
    int k;
    int busy_n;
    bit seen;
    @(negedge clk);
    check("w1 idle", 64'({busy1, done1}), 64'd0);
    a1 = a; b1 = b; cin1 = cin; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; a1 = ~a; b1 = ~b; cin1 = ~cin;
    k = 0; busy_n = 0; seen = 1'b0;
    while (!seen && k < 10) begin
      if (busy1) busy_n++;
      if (done1) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check("w1 latency", 64'(k), 64'd1);
    check("w1 busy cycles", 64'(busy_n), 64'd2);
    check("w1 result", 64'({cout1, sum1}), 64'(exp));
  endtask

  initial begin
    int n_done;
    logic [4:0] e;

    #3;
    check("reset w4", 64'({busy, done, Cout, Sum}), 64'd0);
    check("reset w1", 64'({busy1, done1, cout1, sum1}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;

    do_op(4'h3, 4'h5, 1'b0, 5'h08, 1'b1, "3+5");
    do_op(4'hF, 4'h1, 1'b0, 5'h10, 1'b1, "F+1");
    do_op(4'h7, 4'h8, 1'b1, 5'h10, 1'b1, "7+8+1");

    // Extra starts during RUN and DONE must be ignored.
    @(negedge clk);
    A = 4'h2; B = 4'h2; Cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1; A = 4'hF; B = 4'hF;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("ignore done", 64'(done), 64'd1);
    check("ignore result", 64'({Cout, Sum}), 64'h04);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ignore back idle", 64'({busy, done}), 64'd0);
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("ignore no extra op", 64'(n_done), 64'd0);
    check("ignore sum held", 64'({Cout, Sum}), 64'h04);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    A = 4'h9; B = 4'h9; Cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset outputs", 64'({busy, done, Cout, Sum}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("no done after reset", 64'(n_done), 64'd0);
    last_res = '0;
    do_op(4'h1, 4'h1, 1'b0, 5'h02, 1'b1, "post reset 1+1");

    // All operand combinations in a scrambled order, back-to-back.
    for (int i = 0; i < 512; i++) begin
      int p;
      logic [8:0] pv;
      p  = (i * 197 + 31) % 512;
      pv = p[8:0];
      e  = {1'b0, pv[3:0]} + {1'b0, pv[7:4]} + {4'b0, pv[8]};
      do_op(pv[3:0], pv[7:4], pv[8], e, 1'b0, "sweep4");
    end

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = i[2:0];
      do_op1(v[0], v[1], v[2], {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]});
    end

`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b1;
    do_op(4'h5, 4'h3, 1'b0, 5'h12, 1'b0, "sub 5-3");
    do_op(4'h3, 4'h5, 1'b0, 5'h0E, 1'b0, "sub 3-5");
    do_op(4'h0, 4'h0, 1'b0, 5'h10, 1'b0, "sub 0-0");
    do_op(4'h5, 4'h3, 1'b1, 5'h12, 1'b0, "sub ignores cin");
    sub = 1'b0;
    do_op(4'h5, 4'h3, 1'b0, 5'h08, 1'b0, "sub=0 add");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
